mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Arbiter and sequencer for the single byte-wide RAM port, shared by instruction fetch (IF) and the load/store stage (MEM).
//  Each requester issues a word-level transaction (address, length, direction).
//  The block runs it as a byte-serial RAM access and returns assembled read data with a one-cycle done pulse.
//  Handles branch flush of in-flight fetches and write back-pressure from the IO buffer.
// PARAMETERS
//  ADDR_W   32   width of all addresses and of ram_a
// PORTS
//  clk             in   1        system clock; all state updates on rising edge
//  rst             in   1        reset, asynchronous, active-low
//  if_req          in   1        IF fetch request (always a 4-byte read); held until if_done
//  if_addr         in   ADDR_W   IF fetch byte address
//  if_flush        in   1        branch redirect; cancels any IF transaction
//  if_done         out  1        1-cycle pulse: if_data valid
//  if_data         out  32       fetched word, little-endian
//  mem_req         in   1        MEM request; held until mem_done
//  mem_wr          in   1        1 = store, 0 = load
//  mem_addr        in   ADDR_W   MEM byte address
//  mem_len         in   3        bytes to transfer: 1, 2 or 4 (any other value treated as 4)
//  mem_wdata       in   32       store data; byte k = mem_wdata[8k+7:8k]
//  mem_done        out  1        1-cycle pulse: load data valid / store complete
//  mem_rdata       out  32       load data, zero-extended, little-endian
//  io_buffer_full  in   1        IO write buffer full
//  ram_din         in   8        RAM read data; valid in the cycle after ram_a is sampled
//  ram_dout        out  8        RAM write data
//  ram_a           out  ADDR_W   RAM byte address (registered)
//  ram_wr          out  1        RAM write enable (registered)
//  busy            out  1        high while a transaction is in progress (any state other than IDLE)
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, including if_data and mem_rdata; state=IDLE; internal byte counter=0.
//  States: IDLE, RD, WR, DONE.
//  IDLE accept rules:
//   - mem_req has priority over if_req. No preemption once a transaction starts.
//   - if_req is not accepted on an edge where if_flush=1.
//   - A store with mem_addr[17:16]==2'b11 (IO region) is not accepted while io_buffer_full=1. IF is not blocked by this stall.
//  Accept edge E0: latch addr, len, dir and wdata; counter=0; ram_a<=addr.
//  Read (N bytes):
//   - ram_a<=addr+k at edge Ek, for k=0..N-1.
//   - Byte k is sampled from ram_din at edge E(k+2) into buffer bits [8k+7:8k].
//   - At E(N+1): drive the full word to if_data or mem_rdata (bytes >= N are 0); pulse the matching done; go to DONE.
//  Write (N bytes):
//   - At Ek, k=0..N-1: ram_a<=addr+k, ram_dout<=byte k, ram_wr<=1.
//   - At EN: ram_wr<=0, mem_done<=1, state<=DONE.
//  DONE: lasts exactly one cycle (the done pulse); requests are ignored; next edge goes to IDLE.
//   - This gives the requester one edge to drop req, so a stale req is never double-accepted.
//  Address arithmetic: addr+k is modulo 2^ADDR_W (wraps at top of address space).
//  ram_wr is 0 in every state except WR.
//  Flush:
//   - if_flush=1 at any edge while serving IF: state<=IDLE immediately; no if_done; partial data discarded; ram_a is left as is.
//   - if_flush during a MEM transaction has no effect.
//  Outputs while idle: if_data and mem_rdata hold their last value between transactions; done signals are never high for more than 1 cycle.
//  Reset during an operation aborts it with no done pulse. ram_wr falls to 0 without waiting for clk.
// TESTING
//  1. IF read at 0x100 with RAM bytes 93,00,10,00 -> ram_a = 0x100..0x103 on E0..E3; if_done high for one cycle after E5; if_data=0x00100093.
//  2. In IDLE, if_req and mem_req (wr, len=2, addr 0x200, wdata 0x0000ABCD) arrive together -> write goes first:
//     ram_wr=1 for 2 cycles with (0x200,CD) then (0x201,AB); mem_done pulses; IF accepted on the edge after DONE.
//  3. if_flush=1 at E2 of an IF read -> no if_done, busy=0 next cycle; new if_req at 0x400 accepted on following edge, ram_a=0x400.
//  4. Store len=1 to 0x30000 with io_buffer_full=1 for 10 cycles -> ram_wr stays 0 and busy stays 0;
//     on the first edge with io_buffer_full=0 the request is accepted, then ram_wr pulses once at 0x30000.
//  5. Load len=1 at 0x300 with RAM byte 0xF0 -> mem_rdata=0x000000F0, mem_done one pulse, if_done stays 0.
//  6. Drive rst=0 between edges mid-way through a 4-byte store -> ram_wr, busy and mem_done go to 0 immediately;
//     after rst=1 state is IDLE and no mem_done pulse occurs.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port arbiter/sequencer for IF and MEM requesters
//
// Purpose: accepts word-level transactions from instruction fetch (IF) and the
// load/store stage (MEM), runs each as a byte-serial access on a single
// byte-wide synchronous RAM port, and returns assembled little-endian data
// with a one-cycle done pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr/if_flush  IF fetch request (4-byte read) and branch flush
//   if_done/if_data          IF completion pulse and fetched word
//   mem_req/mem_wr/mem_addr  MEM request, direction, byte address
//   mem_len/mem_wdata        MEM byte count (1, 2, else 4) and store data
//   mem_done/mem_rdata       MEM completion pulse and zero-extended load data
//   io_buffer_full           stalls acceptance of stores into the IO region
//   ram_din/ram_dout         RAM read data (one cycle after ram_a) / write data
//   ram_a/ram_wr             registered RAM address and write enable
//   busy                     high in any state other than IDLE
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_if_q, owner_if_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          len_q, len_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         buf_q, buf_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;

  logic                mem_io_stall;
  logic                accept_mem;
  logic                accept_if;
  logic                flush_hit;
  logic [2:0]          mem_n;
  logic [2:0]          cnt_inc;
  logic [1:0]          byte_idx;
  logic [ADDR_W-1:0]   addr_next;

  // Stores into the IO region (addr[17:16]==3) wait while the IO buffer is full;
  // IF may be accepted in their place since it never writes.
  assign mem_io_stall = mem_wr && (mem_addr[17:16] == 2'b11) && io_buffer_full;
  assign accept_mem   = mem_req && !mem_io_stall;
  assign accept_if    = !accept_mem && if_req && !if_flush;
  assign mem_n        = (mem_len == 3'd1) ? 3'd1 : (mem_len == 3'd2) ? 3'd2 : 3'd4;
  assign flush_hit    = owner_if_q && if_flush;
  assign cnt_inc      = cnt_q + 3'd1;
  // Read data lags the address by two edges, so byte (cnt-1) arrives now.
  assign byte_idx     = cnt_q[1:0] - 2'd1;
  assign addr_next    = addr_q + {{(ADDR_W-3){1'b0}}, cnt_inc};

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      addr_q      <= '0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_mem)     state_d = mem_wr ? WR : RD;
        else if (accept_if) state_d = RD;
      end
      RD: begin
        if (flush_hit)             state_d = IDLE;
        else if (cnt_q == len_q)   state_d = DONE;
      end
      WR: begin
        if (cnt_inc == len_q)      state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / registered-output next values
  always_comb begin
    owner_if_d  = owner_if_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept_mem) begin
          owner_if_d = 1'b0;
          addr_d     = mem_addr;
          len_d      = mem_n;
          cnt_d      = 3'd0;
          wdata_d    = mem_wdata;
          buf_d      = 32'd0;
          ram_a_d    = mem_addr;
          if (mem_wr) begin
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end
        end else if (accept_if) begin
          owner_if_d = 1'b1;
          addr_d     = if_addr;
          len_d      = 3'd4;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          ram_a_d    = if_addr;
        end
      end
      RD: begin
        // A flush abandons the fetch; ram_a and the buffer are left untouched.
        if (!flush_hit) begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) ram_a_d = addr_next;
          if (cnt_q != 3'd0) buf_d[8*byte_idx +: 8] = ram_din;
          if (cnt_q == len_q) begin
            if (owner_if_q) begin
              if_data_d = buf_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = buf_d;
              mem_done_d  = 1'b1;
            end
          end
        end
      end
      WR: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          mem_done_d = 1'b1;
        end else begin
          ram_wr_d   = 1'b1;
          ram_a_d    = addr_next;
          ram_dout_d = wdata_q[8*cnt_inc[1:0] +: 8];
        end
      end
      default: ;
    endcase
  end

  // Output logic
  assign busy      = (state_q != IDLE);
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [2:0]  mem_len = 3'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Memory model contents: written only by the stimulus process.
  bit [7:0] ram [bit [31:0]];
  // RAM write log: appended only by the RAM process.
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .io_buffer_full(io_buffer_full),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    if (ram_wr) begin
      wlog_a.push_back(ram_a);
      wlog_d.push_back(ram_dout);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int eff_len(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ram.exists(a + 32'(k)) ? ram[a + 32'(k)] : 8'h00;
    return w;
  endfunction

  task automatic mem_txn(input bit wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
    int n = eff_len(len);
    int lat = 0;
    int base = wlog_a.size();
    bit seen = 0;
    bit if_seen = 0;
    logic [31:0] exp = model_word(a, n);
    mem_req = 1; mem_wr = wr; mem_addr = a; mem_len = len; mem_wdata = wd;
    while (!seen && lat < 20) begin
      @(negedge clk); lat++;
      if (if_done) if_seen = 1;
      if (mem_done) seen = 1;
    end
    mem_req = 0;
    checks++; if (!seen) begin errors++; $display("FAIL mem_done_timeout addr %h got none want pulse", a); end
    checks++; if (lat != (wr ? n + 1 : n + 2)) begin errors++; $display("FAIL mem_latency addr %h got %0d want %0d", a, lat, wr ? n + 1 : n + 2); end
    checks++; if (if_seen) begin errors++; $display("FAIL if_done_during_mem got 1 want 0"); end
    if (!wr) begin
      checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL load_data addr %h len %0d got %h want %h", a, len, mem_rdata, exp); end
    end else begin
      checks++; if (wlog_a.size() - base != n) begin errors++; $display("FAIL store_count addr %h got %0d want %0d", a, wlog_a.size() - base, n); end
      for (int k = 0; k < n && base + k < wlog_a.size(); k++) begin
        checks++;
        if (wlog_a[base+k] !== a + 32'(k) || wlog_d[base+k] !== wd[8*k +: 8]) begin
          errors++; $display("FAIL store_byte%0d got %h:%h want %h:%h", k, wlog_a[base+k], wlog_d[base+k], a + 32'(k), wd[8*k +: 8]);
        end
      end
      for (int k = 0; k < n; k++) ram[a + 32'(k)] = wd[8*k +: 8];
    end
    @(negedge clk);
    checks++; if (mem_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mem_after_done got done=%b busy=%b want 0 0", mem_done, busy); end
  endtask

  task automatic if_txn(input logic [31:0] a);
    int lat = 0;
    bit seen = 0;
    bit mem_seen = 0;
    logic [31:0] exp = model_word(a, 4);
    if_req = 1; if_addr = a;
    while (!seen && lat < 20) begin
      @(negedge clk); lat++;
      if (mem_done) mem_seen = 1;
      if (if_done) seen = 1;
    end
    if_req = 0;
    checks++; if (!seen || lat != 6) begin errors++; $display("FAIL if_latency addr %h got %0d want 6", a, lat); end
    checks++; if (if_data !== exp || mem_seen) begin errors++; $display("FAIL if_data addr %h got %h want %h", a, if_data, exp); end
    @(negedge clk);
    checks++; if (if_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL if_after_done got done=%b busy=%b want 0 0", if_done, busy); end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_done, mem_done, ram_wr, busy} !== 4'b0 || if_data !== 0 || mem_rdata !== 0 || ram_a !== 0 || ram_dout !== 0) begin
      errors++; $display("FAIL reset_outputs got %b %h %h %h %h want all 0", {if_done, mem_done, ram_wr, busy}, if_data, mem_rdata, ram_a, ram_dout);
    end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    ram[32'h100] = 8'h93; ram[32'h101] = 8'h00; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    if_req = 1; if_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        checks++; if (ram_a !== 32'h100 + 32'(k - 1)) begin errors++; $display("FAIL if_ram_a E%0d got %h want %h", k - 1, ram_a, 32'h100 + 32'(k - 1)); end
      end
      checks++; if (if_done !== 1'(k == 6)) begin errors++; $display("FAIL if_done_timing cyc %0d got %b want %b", k, if_done, k == 6); end
    end
    checks++; if (if_data !== 32'h00100093) begin errors++; $display("FAIL if_data_t1 got %h want 00100093", if_data); end
    if_req = 0;
    @(negedge clk);
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL if_done_pulse got %b want 0", if_done); end
  endtask

  task automatic test_priority();
    ram[32'h500] = 8'h01; ram[32'h501] = 8'h02; ram[32'h502] = 8'h03; ram[32'h503] = 8'h04;
    mem_req = 1; mem_wr = 1; mem_len = 3'd2; mem_addr = 32'h200; mem_wdata = 32'h0000ABCD;
    if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h200, 8'hCD}) begin errors++; $display("FAIL prio_wr0 got %b %h %h want 1 200 cd", ram_wr, ram_a, ram_dout); end
    @(negedge clk);
    checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h201, 8'hAB}) begin errors++; $display("FAIL prio_wr1 got %b %h %h want 1 201 ab", ram_wr, ram_a, ram_dout); end
    @(negedge clk);
    checks++; if ({mem_done, ram_wr, busy} !== 3'b101) begin errors++; $display("FAIL prio_done got %b want 101", {mem_done, ram_wr, busy}); end
    mem_req = 0;
    @(negedge clk);
    checks++; if ({mem_done, busy} !== 2'b00) begin errors++; $display("FAIL prio_idle got %b want 00", {mem_done, busy}); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ram_a !== 32'h500) begin errors++; $display("FAIL prio_if_accept got %b %h want 1 500", busy, ram_a); end
    repeat (5) @(negedge clk);
    checks++; if (if_done !== 1'b1 || if_data !== 32'h04030201) begin errors++; $display("FAIL prio_if_data got %b %h want 1 04030201", if_done, if_data); end
    if_req = 0;
    @(negedge clk);
    mem_wr = 0;
    ram[32'h200] = 8'hCD; ram[32'h201] = 8'hAB;
  endtask

  task automatic test_flush();
    bit early = 0;
    ram[32'h400] = 8'h11; ram[32'h401] = 8'h22; ram[32'h402] = 8'h33; ram[32'h403] = 8'h44;
    if_req = 1; if_addr = 32'h600;
    @(negedge clk);
    @(negedge clk);
    if_flush = 1;
    @(negedge clk);
    checks++; if ({busy, if_done} !== 2'b00) begin errors++; $display("FAIL flush_idle got %b want 00", {busy, if_done}); end
    if_flush = 0; if_addr = 32'h400;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ram_a !== 32'h400) begin errors++; $display("FAIL flush_reaccept got %b %h want 1 400", busy, ram_a); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (if_done) early = 1;
    end
    @(negedge clk);
    checks++; if (early || if_done !== 1'b1 || if_data !== 32'h44332211) begin errors++; $display("FAIL flush_refetch got early=%b %b %h want 0 1 44332211", early, if_done, if_data); end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_io_stall();
    int base = wlog_a.size();
    bit bad = 0;
    mem_req = 1; mem_wr = 1; mem_len = 3'd1; mem_addr = 32'h30000; mem_wdata = 32'h0000005A;
    io_buffer_full = 1;
    repeat (10) begin
      @(negedge clk);
      if (ram_wr !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL io_stall got activity want ram_wr=0 busy=0"); end
    io_buffer_full = 0;
    @(negedge clk);
    checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h30000, 8'h5A}) begin errors++; $display("FAIL io_write got %b %h %h want 1 30000 5a", ram_wr, ram_a, ram_dout); end
    @(negedge clk);
    checks++; if ({mem_done, ram_wr} !== 2'b10) begin errors++; $display("FAIL io_done got %b want 10", {mem_done, ram_wr}); end
    mem_req = 0;
    @(negedge clk);
    checks++; if (wlog_a.size() - base != 1) begin errors++; $display("FAIL io_write_count got %0d want 1", wlog_a.size() - base); end
    ram[32'h30000] = 8'h5A;
  endtask

  task automatic test_load_byte();
    ram[32'h300] = 8'hF0;
    mem_txn(1'b0, 32'h300, 3'd1, 32'd0);
    checks++; if (mem_rdata !== 32'h000000F0) begin errors++; $display("FAIL load_byte got %h want 000000f0", mem_rdata); end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    mem_req = 1; mem_wr = 1; mem_len = 3'd4; mem_addr = 32'h700; mem_wdata = 32'h87654321;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    #1;
    checks++; if ({ram_wr, busy, mem_done} !== 3'b000) begin errors++; $display("FAIL async_reset got %b want 000", {ram_wr, busy, mem_done}); end
    @(negedge clk);
    mem_req = 0; mem_wr = 0; rst = 1;
    repeat (6) begin
      @(negedge clk);
      if (mem_done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL reset_abort got done/busy want 0"); end
    ram[32'h700] = 8'h21; ram[32'h701] = 8'h43;
  endtask

  task automatic test_wrap();
    mem_txn(1'b1, 32'hFFFFFFFE, 3'd4, 32'hDEADBEEF);
    mem_txn(1'b0, 32'hFFFFFFFE, 3'd4, 32'd0);
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_load got %h want deadbeef", mem_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'h000000, 8'($urandom)};
      logic [2:0]  len = 3'($urandom_range(0, 7));
      int kind = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++) if (!ram.exists(a + 32'(k))) ram[a + 32'(k)] = 8'($urandom);
      case (kind)
        0:       mem_txn(1'b1, a, len, $urandom);
        1:       mem_txn(1'b0, a, len, 32'd0);
        default: if_txn(a);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_flush();
    test_io_stall();
    test_load_byte();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
